// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 7-segment driver with frame-coherent snapshot,
// inter-digit ghost blanking and optional leading-zero blanking.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    input  logic                          lz_blank,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [7:0]                    seg,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic                    lz_q, lz_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    slot_end, frame_end, active, blank, dp_cur;
    logic [3:0]              cur;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        slot_end  = 32'(cnt_q) == REFRESH_DIV - 1;
        frame_end = slot_end && 32'(idx_q) == NUM_DIGITS - 1;
        active    = 32'(cnt_q) >= BLANK_CYCLES;
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = frame_end ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
        dig_d     = frame_end ? digits : dig_q;
        dp_d      = frame_end ? dp_mask : dp_q;
        lz_d      = frame_end ? lz_blank : lz_q;
        cur       = '0;
        dp_cur    = 1'b0;
        // a digit is blanked only if it and every more significant digit are zero
        blank     = lz_q && idx_q != '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                cur    = dig_q[4*i +: 4];
                dp_cur = dp_q[i];
            end
            if (IW'(i) >= idx_q && dig_q[4*i +: 4] != 4'h0) blank = 1'b0;
        end
        an_d  = active ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d = active ? {~dp_cur, blank ? 7'h7F : decode(cur)} : 8'hFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            dig_q <= '0;
            dp_q  <= '0;
            lz_q  <= 1'b0;
            an_q  <= '1;
            seg_q <= 8'hFF;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            dig_q <= dig_d;
            dp_q  <= dp_d;
            lz_q  <= lz_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign digit_idx = idx_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: random and directed stimulus checked against a cycle-indexed
// model that derives slot, frame and snapshot from elapsed clock count.
module tb_seven_seg_scanner;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  digit_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;

    logic [15:0] hd [0:1023];
    logic [3:0]  hp [0:1023];
    logic        hl [0:1023];

    localparam logic [6:0] DEC [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .digits(digits), .dp_mask(dp_mask),
        .lz_blank(lz_blank), .an(an), .seg(seg), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got %h expected %h", tag, k, got, exp);
        end
    endtask

    // Expected {digit_idx, an, seg} after kk clock edges since reset release.
    function automatic logic [13:0] model(input int kk);
        int s, ix;
        logic [15:0] d;
        logic [3:0]  p, a;
        logic        l, bl;
        logic [7:0]  sg;
        if (kk == 0) return {2'd0, 4'hF, 8'hFF};
        s  = kk - 1;
        ix = (s / 4) % 4;
        d  = s < 16 ? 16'h0 : hd[(s / 16) * 16 - 1];
        p  = s < 16 ? 4'h0 : hp[(s / 16) * 16 - 1];
        l  = s < 16 ? 1'b0 : hl[(s / 16) * 16 - 1];
        bl = l && ix > 0 && (d >> (4 * ix)) == 16'h0;
        a  = s % 4 < 1 ? 4'hF : ~(4'b1 << ix);
        sg = s % 4 < 1 ? 8'hFF : {~p[ix], bl ? 7'h7F : DEC[4'(d >> (4 * ix))]};
        return {2'((kk / 4) % 4), a, sg};
    endfunction

    task automatic step(input bit hold);
        logic [13:0] e;
        e = model(k);
        chk("digit_idx", {6'd0, digit_idx}, {6'd0, e[13:12]});
        chk("an", {4'd0, an}, {4'd0, e[11:8]});
        chk("seg", seg, e[7:0]);
        if (!hold && $urandom_range(5) == 0) begin
            digits   = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3)));
            dp_mask  = 4'($urandom);
            lz_blank = 1'($urandom);
        end
        hd[k] = digits;
        hp[k] = dp_mask;
        hl[k] = lz_blank;
        @(negedge clk);
        k++;
    endtask

    initial begin
        reset    = 1'b1;
        digits   = 16'h1234;
        dp_mask  = 4'h0;
        lz_blank = 1'b0;
        #12;
        chk("reset_an", {4'd0, an}, 8'h0F);
        chk("reset_seg", seg, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        k     = 0;
        for (int i = 0; i < 40; i++) step(1'b1);
        while (model(k + 1)[13:12] != 2'd2) step(1'b1);
        digits = 16'hABCD;
        for (int i = 0; i < 40; i++) step(1'b1);
        digits   = 16'h0050;
        lz_blank = 1'b1;
        dp_mask  = 4'b1000;
        for (int i = 0; i < 40; i++) step(1'b1);
        lz_blank = 1'b0;
        for (int i = 0; i < 36; i++) step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b0);
        for (int i = 0; i < 20 && model(k)[11:8] != 4'b1011; i++) step(1'b0);
        chk("pre_reset_an", {4'd0, an}, 8'h0B);
        #2 reset = 1'b1;
        #1;
        chk("async_an", {4'd0, an}, 8'h0F);
        chk("async_seg", seg, 8'hFF);
        chk("async_idx", {6'd0, digit_idx}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        k     = 0;
        for (int i = 0; i < 200; i++) step(1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
